remote_comm: RTL and testbench

//  Command-side transceiver between the bench/host and the Knight's UART link.

---
 rtl/remote_comm.sv | 163 ++++++++++++++++
 tb/tb_remote_comm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/remote_comm.sv
// Command-side UART transceiver: sends a 16-bit command as two 8N1 frames
// (high byte first) and captures single-byte responses from the link.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        RST_n,
  input  logic        send_cmd,
  input  logic [15:0] cmd,
  input  logic        RX,
  output logic        TX,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam logic [11:0] BIT_END  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_END = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   tx_state;
  logic [9:0]  tx_sr;
  logic [11:0] tx_baud;
  logic [3:0]  tx_bit;
  logic        armed;
  logic [7:0]  cmd_lo_hold;
  logic        accept;

  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [11:0] rx_baud;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_sr;

  // A new command is taken only after send_cmd has been seen low since the last one.
  assign accept = (tx_state == TX_IDLE) && send_cmd && armed;

  // TX: line is the LSB of a frame shift register that back-fills with idle ones.
  assign TX = tx_sr[0];

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      tx_state <= TX_IDLE;
      tx_sr    <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      armed    <= 1'b1;
      cmd_sent <= 1'b0;
    end else begin
      if (!send_cmd) armed <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (accept) begin
            armed    <= 1'b0;
            cmd_sent <= 1'b0;
            tx_sr    <= {1'b1, cmd[15:8], 1'b0};
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_state <= TX_HIGH;
          end
        end
        TX_HIGH, TX_LOW: begin
          if (tx_baud == BIT_END) begin
            tx_baud <= '0;
            if (tx_bit == 4'd9) begin
              tx_bit <= '0;
              if (tx_state == TX_HIGH) begin
                tx_sr    <= {1'b1, cmd_lo_hold, 1'b0};
                tx_state <= TX_LOW;
              end else begin
                tx_sr    <= '1;
                cmd_sent <= 1'b1;
                tx_state <= TX_IDLE;
              end
            end else begin
              tx_bit <= tx_bit + 4'd1;
              tx_sr  <= {1'b1, tx_sr[9:1]};
            end
          end else begin
            tx_baud <= tx_baud + 12'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) cmd_lo_hold <= cmd[7:0];
  end

  // RX synchroniser; rx_prev gives a falling-edge detect on the synced line.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      resp_rdy <= 1'b0;
      resp     <= 8'h00;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            resp_rdy <= 1'b0;
            rx_baud  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_baud == HALF_END) begin
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud <= rx_baud + 12'd1;
          end
        end
        RX_DATA: begin
          if (rx_baud == BIT_END) begin
            rx_baud <= '0;
            if (rx_bit == 4'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 4'd1;
          end else begin
            rx_baud <= rx_baud + 12'd1;
          end
        end
        RX_STOP: begin
          if (rx_baud == BIT_END) begin
            rx_baud  <= '0;
            rx_state <= RX_IDLE;
            // A low stop bit is a framing error: the byte is dropped.
            if (rx_s2) begin
              resp     <= rx_sr;
              resp_rdy <= 1'b1;
            end
          end else begin
            rx_baud <= rx_baud + 12'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_baud == BIT_END) rx_sr <= {rx_s2, rx_sr[7:1]};
  end

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: randomized commands and responses checked against
// frame timing computed from the UART 8N1 rules.
module tb_remote_comm;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        RST_n;
  logic        send_cmd;
  logic [15:0] cmd;
  logic        RX;
  logic        TX;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  model_resp = 8'h00;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk(clk), .RST_n(RST_n), .send_cmd(send_cmd), .cmd(cmd), .RX(RX),
    .TX(TX), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one command; expected TX level at each mid-bit comes from the frame layout.
  task automatic send_cmd_chk(input logic [15:0] c, input int hold_n, input bit pulse_mid);
    int rises;
    logic prev;
    logic [7:0] byt;
    logic [9:0] f;
    rises = 0;
    prev  = 1'b0;
    @(negedge clk);
    send_cmd = 1'b1;
    cmd      = c;
    @(posedge clk);
    for (int k = 0; k < 360; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("sent_clr", 32'(cmd_sent), 32'd0);
        prev = cmd_sent;
      end else begin
        if (cmd_sent && !prev) rises++;
        prev = cmd_sent;
      end
      if (k == hold_n - 1) begin
        send_cmd = 1'b0;
        cmd      = 16'($urandom);
      end
      if (pulse_mid && k == 60) begin
        send_cmd = 1'b1;
        cmd      = 16'h1234;
      end
      if (pulse_mid && k == 62) send_cmd = 1'b0;
      if (k % BD == BD / 2) begin
        if (k < 20 * BD) begin
          byt = (k < 10 * BD) ? c[15:8] : c[7:0];
          f   = {1'b1, byt, 1'b0};
          check("tx_bit", 32'(TX), 32'(f[(k / BD) % 10]));
        end else begin
          check("tx_idle", 32'(TX), 32'd1);
        end
      end
      if (k == 20 * BD - 3) check("sent_early", 32'(cmd_sent), 32'd0);
      if (k == 20 * BD + 2) check("sent_set", 32'(cmd_sent), 32'd1);
    end
    check("sent_once", 32'(rises), 32'd1);
    check("sent_hold", 32'(cmd_sent), 32'd1);
  endtask

  // Drive one 8N1 byte on RX; good=0 makes the stop bit low.
  task automatic rx_byte(input logic [7:0] b, input bit good);
    logic [9:0] f;
    f = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < BD; j++) begin
        @(negedge clk);
        RX = f[i];
        if (i == 0 && j == 12) begin
          check("rdy_clr", 32'(resp_rdy), 32'd0);
          check("resp_keep", 32'(resp), 32'(model_resp));
        end
      end
    end
    @(negedge clk);
    RX = 1'b1;
    if (good) model_resp = b;
    repeat (4) @(negedge clk);
    check("resp", 32'(resp), 32'(model_resp));
    check("rdy", 32'(resp_rdy), 32'(good));
  endtask

  initial begin
    RST_n    = 1'b0;
    send_cmd = 1'b0;
    cmd      = 16'h0000;
    RX       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_sent", 32'(cmd_sent), 32'd0);
    check("rst_rdy", 32'(resp_rdy), 32'd0);
    check("rst_resp", 32'(resp), 32'd0);
    RST_n = 1'b1;
    repeat (5) @(negedge clk);

    send_cmd_chk(16'h2A5F, 10, 1'b0);

    rx_byte(8'hA5, 1'b1);
    rx_byte(8'h5A, 1'b1);

    // A second request during the first frame must be ignored.
    send_cmd_chk(16'($urandom), 3, 1'b1);

    // send_cmd held high across completion must not start another command.
    send_cmd_chk(16'($urandom), 1000, 1'b0);
    repeat (30) @(negedge clk);
    check("no_retrig_tx", 32'(TX), 32'd1);
    check("no_retrig_sent", 32'(cmd_sent), 32'd1);
    send_cmd = 1'b0;
    repeat (3) @(negedge clk);

    rx_byte(8'h33, 1'b0);
    @(negedge clk);
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rdy", 32'(resp_rdy), 32'd0);
    check("glitch_resp", 32'(resp), 32'(model_resp));

    for (int n = 0; n < 3; n++) begin
      send_cmd_chk(16'($urandom), int'($urandom_range(1, 20)), 1'b0);
      rx_byte(8'($urandom), 1'($urandom_range(0, 1)));
    end

    fork
      send_cmd_chk(16'($urandom), 4, 1'b0);
      begin
        repeat (100) @(negedge clk);
        rx_byte(8'($urandom), 1'b1);
      end
    join
    repeat (5) @(negedge clk);
    rx_byte(8'($urandom) | 8'h01, 1'b1);

    // Reset in the middle of the low-byte frame of 16'hBEEF.
    @(negedge clk);
    send_cmd = 1'b1;
    cmd      = 16'hBEEF;
    for (int k = 0; k < 360; k++) begin
      @(negedge clk);
      if (k == 2) send_cmd = 1'b0;
      if (k == 200) begin
        RST_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(TX), 32'd1);
        check("mid_rst_sent", 32'(cmd_sent), 32'd0);
        check("mid_rst_rdy", 32'(resp_rdy), 32'd0);
        check("mid_rst_resp", 32'(resp), 32'd0);
        model_resp = 8'h00;
      end
      if (k == 203) RST_n = 1'b1;
      if (k > 203 && k % BD == BD / 2) check("post_rst_tx", 32'(TX), 32'd1);
    end
    check("post_rst_sent", 32'(cmd_sent), 32'd0);
    check("post_rst_resp", 32'(resp), 32'(model_resp));

    send_cmd_chk(16'($urandom), 4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
